data_mem_responder: RTL
=======================

# data_mem_responder

Data-memory responder for the core: the memory-side end of the load/store request that the control unit issues with `wr_en`/`rd_en`. Accepts one request at a time via a valid/ready handshake and decodes `func3` into byte, halfword or word access. Performs the access into an internal word-organised RAM after a programmable latency, then returns load data sign- or zero-extended, or an error, as a one-cycle response pulse.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the RAM; the word index is `addr[31:2]`.
- `LATENCY`, 2: cycles from the accept edge to the commit/response edge; legal range 1..15.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: responder can accept a request; equals (state == IDLE).
- `wr_en` in 1: request is a store.
- `rd_en` in 1: request is a load.
- `addr` in 32: byte address.
- `wdata` in 32: store data (the rs2 value), right-aligned.
- `func3` in 3: access size and sign, RV32I encoding.
- `resp_valid` out 1: one-cycle response pulse.
- `rdata` out 32: load result; 0 for stores and errors.
- `resp_err` out 1: request was rejected; qualified by `resp_valid`.
- `busy` out 1: equals (state != IDLE).

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: accept on `req_valid && req_ready`. Latch `wr_en`, `rd_en`, `addr`, `wdata` and `func3`, compute the error flag, load `cnt = LATENCY-1`, and go to WAIT. With no request, stay in IDLE.
  - WAIT: if `cnt != 0`, decrement `cnt`. If `cnt == 0`, commit the access, register `rdata`/`resp_err`, and go to RESP.
  - RESP: `resp_valid = 1` for exactly this cycle, then return to IDLE unconditionally.
- Loads, selected by `func3`:
  - 000 LB: sign-extend byte `addr[1:0]`.
  - 001 LH: sign-extend halfword `addr[1]`.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
- Stores, selected by `func3`:
  - 000 SB: write `wdata[7:0]` to byte lane `addr[1:0]`.
  - 001 SH: write `wdata[15:0]` to halfword lane `addr[1]`.
  - 010 SW: write the full word.
  - Lanes not selected are unchanged.
- Error conditions (any one sets the error flag):
  - `wr_en == rd_en`, i.e. both enables high or both low.
  - Illegal `func3`: 011, 110 or 111 for loads; anything other than 000, 001 or 010 for stores.
  - Misaligned access: a halfword with `addr[0]` = 1, or a word with `addr[1:0]` != 0.
  - Out of range: `addr[31:2] >= DEPTH_WORDS`.
- Handling of an errored request:
  - It still traverses WAIT and RESP with the same latency.
  - No RAM write occurs.
  - The response carries `rdata = 0` and `resp_err = 1`.
- Stores return `rdata = 0` and `resp_err = 0` on success.
- Inputs are sampled only at the accept edge; changes to them during WAIT or RESP have no effect.
- `rdata` and `resp_err` are registered and hold their values until the next commit edge.

## Timing
- Reset values: state IDLE, `cnt = 0`, `resp_valid = 0`, `rdata = 0`, `resp_err = 0`, `busy = 0`, `req_ready = 1`.
- RAM contents are not reset.
- Accept at edge k. The store is written, or the load data captured, at edge k+LATENCY. `resp_valid` is high from edge k+LATENCY until edge k+LATENCY+1.
- `req_ready` is low from edge k to edge k+LATENCY+1. The earliest next accept is edge k+LATENCY+2, giving a throughput of one request per LATENCY+2 cycles.
- Holding `req_valid` high continuously produces accepts exactly LATENCY+2 cycles apart.
- A load issued after a store's response reads the updated data; there is no bypass requirement because requests never overlap.
- Reset asserted mid-operation: return to IDLE immediately and clear all outputs.
  - A store still in WAIT is discarded and the RAM is unchanged.
  - A store already committed stays written.
  - No response is issued for an aborted request.
- `req_valid` while busy is ignored; it is not queued.

## Test plan
- LATENCY=2: SW 0xDEADBEEF to 0x10, then LW 0x10. Each response arrives 2 cycles after accept with `resp_err = 0`; the load returns 0xDEADBEEF.
- Byte store and loads after the previous test:
  - SB `wdata = 0x00000080` to 0x13.
  - LB 0x13 returns 0xFFFFFF80.
  - LBU 0x13 returns 0x00000080.
  - LW 0x10 returns 0x80ADBEEF.
- Halfword and misaligned accesses:
  - SH 0x1234 to 0x12, then LH 0x12 returns 0x00001234.
  - LH 0x11 gives `resp_err = 1` and `rdata = 0`.
  - SW to 0x12 gives `resp_err = 1`; a following LW 0x10 returns 0x1234BEEF.
- Rejected requests:
  - LW to address DEPTH_WORDS*4 gives an error.
  - `func3` = 011 on a load gives an error.
  - `wr_en = rd_en = 1` gives an error with no write.
  - Each still pulses `resp_valid` exactly once.
- Reset mid-operation: with LATENCY=4, issue SW 0xCAFEF00D to 0x20 and assert `rst` 2 cycles after accept.
  - All outputs are immediately 0 and `req_ready = 1`.
  - No `resp_valid` is seen.
  - A later LW 0x20 returns the prior contents.
- Back-to-back: with LATENCY=3, hold `req_valid` high for 4 loads. Accepts occur every 5 cycles, each `resp_valid` is exactly 1 cycle wide, and `busy` is the inverse of `req_ready` throughout.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core's load/store control and the
// data-memory responder.
//   master : drives req_valid, wr_en, rd_en, addr, wdata, func3;
//            observes req_ready, resp_valid, rdata, resp_err, busy
//   slave  : the responder side (directions reversed)
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  func3;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, wr_en, rd_en, addr, wdata, func3,
    input  req_ready, resp_valid, rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, wr_en, rd_en, addr, wdata, func3,
    output req_ready, resp_valid, rdata, resp_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, performs the access on a word-organised RAM and returns a single
// cycle response carrying sign/zero-extended load data or an error flag.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (RAM contents are not reset)
//   bus  - slave side of data_mem_responder_if (request handshake,
//          access attributes, response pulse, busy/ready status)
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [31:0] W_DEPTH  = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_commit;
  logic [3:0]         r_cnt;
  logic               r_wr;
  logic               r_err;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [2:0]         r_func3;
  logic               r_req_ready;
  logic               r_busy;
  logic               r_resp_valid;
  logic [31:0]        r_rdata;
  logic               r_resp_err;
  logic [IDX_W-1:0]   w_idx;
  logic [31:0]        r_mem [DEPTH_WORDS];

  // Rejection rules: enable conflict, illegal size code, misalignment, range.
  function automatic logic f_req_err(input logic wr, input logic rd,
                                     input logic [31:0] addr, input logic [2:0] f3);
    logic bad_f3;
    logic misal;
    logic out_rng;
    if (wr) begin
      case (f3)
        3'b000, 3'b001, 3'b010: bad_f3 = 1'b0;
        default:                bad_f3 = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad_f3 = 1'b0;
        default:                                bad_f3 = 1'b1;
      endcase
    end
    // f3[1:0] encodes size for both loads and stores (00 byte, 01 half, 10 word)
    case (f3[1:0])
      2'b01:   misal = addr[0];
      2'b10:   misal = (addr[1:0] != 2'b00);
      default: misal = 1'b0;
    endcase
    out_rng = ({2'b00, addr[31:2]} >= W_DEPTH);
    return (wr == rd) | bad_f3 | misal | out_rng;
  endfunction

  // Extract and extend the addressed byte/halfword/word of a RAM word.
  function automatic logic [31:0] f_load_ext(input logic [31:0] word,
                                             input logic [2:0] f3, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b010:  res = word;
      3'b100:  res = {24'h000000, b};
      3'b101:  res = {16'h0000, h};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Merge store data into the selected lane(s), leaving other lanes intact.
  function automatic logic [31:0] f_store_merge(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] res;
    res = old;
    case (f3)
      3'b000: res[{off, 3'b000} +: 8] = wd[7:0];
      3'b001: begin
        if (off[1]) res[31:16] = wd[15:0];
        else        res[15:0]  = wd[15:0];
      end
      3'b010:  res = wd;
      default: res = old;
    endcase
    return res;
  endfunction

  assign w_idx = r_addr[IDX_W+1:2];

  // Next-state decode: accept in IDLE, count down in WAIT, single RESP cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_commit    = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, latched request, countdown and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_wr         <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= 32'h0000_0000;
      r_wdata      <= 32'h0000_0000;
      r_func3      <= 3'b000;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'h0000_0000;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      // Status outputs are registered copies of the decoded next state.
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_resp_valid <= (w_state_nxt == S_RESP);
      if (w_accept) begin
        r_cnt   <= CNT_LOAD;
        r_wr    <= bus.wr_en;
        r_err   <= f_req_err(bus.wr_en, bus.rd_en, bus.addr, bus.func3);
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_func3 <= bus.func3;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_resp_err <= r_err;
        r_rdata    <= (r_err || r_wr) ? 32'h0000_0000
                                      : f_load_ext(r_mem[w_idx], r_func3, r_addr[1:0]);
      end
    end
  end

  // RAM write port; an aborted request never reaches w_commit.
  always_ff @(posedge clk) begin
    if (w_commit && r_wr && !r_err) begin
      r_mem[w_idx] <= f_store_merge(r_mem[w_idx], r_wdata, r_func3, r_addr[1:0]);
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.busy       = r_busy;
  assign bus.resp_valid = r_resp_valid;
  assign bus.rdata      = r_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule
